// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and controller state encoding for the UART receive path.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_CHAR_TICKS = 160;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: DEPTH x 8 synchronous FIFO with a registered head (no fall-through).
// A push with a simultaneous pop is accepted even when full.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          do_push;
  logic          do_pop;
  logic          last_out;
  logic [7:0]    head_nx;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);
  assign rd_ptr_nx = rd_ptr + AW'(do_pop);
  assign count_nx  = count + CW'(do_push) - CW'(do_pop);
  assign last_out  = (count == CW'(do_pop));
  assign fill      = count;

  // Next head value: a push into an (effectively) empty FIFO lands directly in the head.
  always_comb begin
    head_nx = dout;
    if (do_push && last_out) begin
      head_nx = din;
    end else if (count_nx != '0) begin
      head_nx = mem[rd_ptr_nx];
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
      valid  <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr_nx;
      count  <= count_nx;
      dout   <= head_nx;
      valid  <= (count_nx != '0);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversample tick divider, idle-line sync, byte capture FIFO and status flags.
// Optional inter-character idle detector: define UART_RX_CTRL_IDLE_TIMEOUT_EN.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned IDLE_CHARS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_en,
  input  logic [15:0]            cfg_div,
  input  logic                   clr_ovr,
  input  logic                   i_rxd,
  input  logic                   rx_done,
  input  logic [7:0]             rx_data,
  output logic                   o_clk_rx,
  output logic                   o_rx_en,
  output logic                   m_valid,
  output logic [7:0]             m_data,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic                   o_overrun,
  output logic                   o_idle
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned SYNC_W = $clog2(UART_OVERSAMPLE);

  state_e            state;
  state_e            next_state;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_last;
  logic [SYNC_W-1:0] sync_cnt;
  logic              rx_done_q;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              ovr_set;
  logic              qual_tick;
  logic              clk_rx_nx;
  logic              rx_en_nx;

  assign div_last  = (div_q <= DIV_W'(1)) ? '0 : div_q - DIV_W'(1);
  assign qual_tick = o_clk_rx & i_rxd;
  assign push      = (state == RUN) & rx_done & ~rx_done_q;
  assign pop       = m_valid & m_ready;
  assign ovr_set   = push & fifo_full & ~pop;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= OFF;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      OFF: begin
        if (cfg_en) next_state = SYNC;
      end
      SYNC: begin
        if (!cfg_en) begin
          next_state = OFF;
        end else if (qual_tick && (sync_cnt == SYNC_W'(UART_OVERSAMPLE - 1))) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (!cfg_en) next_state = DRAIN;
      end
      DRAIN: begin
        if (cfg_en) begin
          next_state = SYNC;
        end else if (fifo_empty) begin
          next_state = OFF;
        end
      end
      default: next_state = OFF;
    endcase
  end

  // Output decode for the coming cycle; the tick needs a running divider on both sides of the edge.
  always_comb begin
    rx_en_nx  = 1'b0;
    clk_rx_nx = 1'b0;
    if (next_state == RUN) begin
      rx_en_nx = 1'b1;
    end
    if ((state != OFF) && (next_state != OFF) && (div_cnt == div_last)) begin
      clk_rx_nx = 1'b1;
    end
  end

  // Divider and registered outputs; the enabling OFF cycle counts as phase 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      div_cnt  <= '0;
      o_clk_rx <= 1'b0;
      o_rx_en  <= 1'b0;
    end else begin
      o_clk_rx <= clk_rx_nx;
      o_rx_en  <= rx_en_nx;
      if (state == OFF) begin
        if (cfg_en) begin
          div_q   <= cfg_div;
          div_cnt <= (cfg_div <= DIV_W'(1)) ? '0 : DIV_W'(1);
        end else begin
          div_cnt <= '0;
        end
      end else if (div_cnt >= div_last) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Consecutive idle-line ticks while synchronizing.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_cnt <= '0;
    end else if (state != SYNC) begin
      sync_cnt <= '0;
    end else if (o_clk_rx) begin
      sync_cnt <= i_rxd ? sync_cnt + SYNC_W'(1) : '0;
    end
  end

  // Strobe edge detect and sticky overrun; a new overrun beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_done_q <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (ovr_set) begin
        o_overrun <= 1'b1;
      end else if (clr_ovr) begin
        o_overrun <= 1'b0;
      end
    end
  end

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (m_data),
    .valid (m_valid),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (o_fill)
  );

`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
  localparam int unsigned IDLE_TICKS = IDLE_CHARS * UART_CHAR_TICKS;
  localparam int unsigned IDLE_W     = $clog2(IDLE_TICKS + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              idle_armed;

  // Idle-gap timer: one pulse per captured byte once the line stays high long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt   <= '0;
      idle_armed <= 1'b0;
      o_idle     <= 1'b0;
    end else begin
      o_idle <= 1'b0;
      if (push) begin
        idle_armed <= 1'b1;
      end
      if ((state != RUN) || rx_done) begin
        idle_cnt <= '0;
      end else if (o_clk_rx) begin
        if (!i_rxd) begin
          idle_cnt <= '0;
        end else if (idle_armed) begin
          if (idle_cnt == IDLE_W'(IDLE_TICKS - 1)) begin
            idle_cnt   <= '0;
            idle_armed <= 1'b0;
            o_idle     <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
      end
    end
  end
`else
  logic idle_unused;

  // Idle detection not built.
  assign idle_unused = (IDLE_CHARS == 0);
  assign o_idle      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized stimulus against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int DEPTH      = 4;
  localparam int IDLE_CHARS = 2;
  localparam int FW         = $clog2(DEPTH) + 1;
`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
  localparam int EXP_PULSES = 1;
  localparam int EXP_FIRST  = IDLE_CHARS * 160 + 1;
`else
  localparam int EXP_PULSES = 0;
  localparam int EXP_FIRST  = -1;
`endif

  logic          clk     = 1'b0;
  logic          reset   = 1'b1;
  logic          cfg_en  = 1'b0;
  logic [15:0]   cfg_div = 16'd4;
  logic          clr_ovr = 1'b0;
  logic          i_rxd   = 1'b1;
  logic          rx_done = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          m_ready = 1'b0;
  logic          o_clk_rx, o_rx_en, m_valid, o_overrun, o_idle;
  logic [7:0]    m_data;
  logic [FW-1:0] o_fill;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(
    .DEPTH      (DEPTH),
    .IDLE_CHARS (IDLE_CHARS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .clr_ovr   (clr_ovr),
    .i_rxd     (i_rxd),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .o_clk_rx  (o_clk_rx),
    .o_rx_en   (o_rx_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .o_fill    (o_fill),
    .o_overrun (o_overrun),
    .o_idle    (o_idle)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Modes: 0 off, 1 sync, 2 run, 3 drain. Ticks come from the cycle index since enable.
  int            m_st = 0, m_c = 0, m_div = 0, m_sync = 0, m_idle_cnt = 0;
  bit            m_armed = 0, m_prev_done = 0, model_live = 0;
  byte unsigned  q[$];
  bit            e_tick = 0, e_rx_en = 0, e_valid = 0, e_ovr = 0, e_idle = 0;
  byte unsigned  e_data = 0;
  int            e_fill = 0;

  always @(posedge clk) begin : model
    int pre;
    bit pop, push, tick, ovr_now;
    if (reset) begin
      m_st = 0; m_c = 0; m_sync = 0; m_idle_cnt = 0; m_armed = 0; m_prev_done = 0;
      q.delete();
      e_tick = 0; e_rx_en = 0; e_valid = 0; e_ovr = 0; e_idle = 0; e_data = 0; e_fill = 0;
      model_live = 1;
    end else begin
      tick    = e_tick;
      pre     = q.size();
      pop     = e_valid && m_ready;
      push    = (m_st == 2) && rx_done && !m_prev_done;
      ovr_now = push && (pre == DEPTH) && !pop;
      e_idle  = 0;
      if (pop) void'(q.pop_front());
      if (push && !ovr_now) q.push_back(rx_data);
      if (ovr_now) e_ovr = 1;
      else if (clr_ovr) e_ovr = 0;
`ifdef UART_RX_CTRL_IDLE_TIMEOUT_EN
      if (push) m_armed = 1;
      if (m_st != 2 || rx_done) m_idle_cnt = 0;
      else if (tick) begin
        if (!i_rxd) m_idle_cnt = 0;
        else if (m_armed) begin
          m_idle_cnt++;
          if (m_idle_cnt == IDLE_CHARS * 160) begin
            e_idle = 1; m_armed = 0; m_idle_cnt = 0;
          end
        end
      end
`endif
      case (m_st)
        0: if (cfg_en) begin m_st = 1; m_c = 0; m_div = int'(cfg_div); m_sync = 0; end
        1: if (!cfg_en) m_st = 0;
           else if (tick) begin
             m_sync = i_rxd ? m_sync + 1 : 0;
             if (m_sync == 16) m_st = 2;
           end
        2: if (!cfg_en) m_st = 3;
        default: if (cfg_en) begin m_st = 1; m_sync = 0; end
                 else if (pre == 0) m_st = 0;
      endcase
      if (m_st != 0) m_c++;
      e_tick  = (m_st != 0) && ((m_div <= 1) ? (m_c >= 2) : (m_c % m_div == 0));
      e_rx_en = (m_st == 2);
      e_valid = (q.size() != 0);
      if (e_valid) e_data = q[0];
      e_fill  = q.size();
      m_prev_done = rx_done;
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (model_live) begin
      cmp("o_clk_rx", 32'(o_clk_rx), 32'(e_tick));
      cmp("o_rx_en", 32'(o_rx_en), 32'(e_rx_en));
      cmp("m_valid", 32'(m_valid), 32'(e_valid));
      cmp("o_fill", 32'(o_fill), 32'(e_fill));
      cmp("o_overrun", 32'(o_overrun), 32'(e_ovr));
      cmp("o_idle", 32'(o_idle), 32'(e_idle));
      if (e_valid) cmp("m_data", 32'(m_data), 32'(e_data));
    end
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    byte unsigned exp4[4];
    int n, pulses, first;

    // Reset state.
    reset = 1'b1;
    step(3);
    cmp("rst_clk_rx", 32'(o_clk_rx), 0);
    cmp("rst_rx_en", 32'(o_rx_en), 0);
    cmp("rst_m_valid", 32'(m_valid), 0);
    cmp("rst_m_data", 32'(m_data), 0);
    cmp("rst_fill", 32'(o_fill), 0);
    cmp("rst_overrun", 32'(o_overrun), 0);
    cmp("rst_idle", 32'(o_idle), 0);

    // Basic capture, divisor 4.
    reset = 1'b0; cfg_div = 16'd4; i_rxd = 1'b1; cfg_en = 1'b1;
    step(3);  cmp("tick_c3", 32'(o_clk_rx), 0);
    step(1);  cmp("tick_c4", 32'(o_clk_rx), 1);
    step(60); cmp("rx_en_c64", 32'(o_rx_en), 0);
    cmp("tick_c64", 32'(o_clk_rx), 1);
    step(1);  cmp("rx_en_c65", 32'(o_rx_en), 1);
    step(2);
    rx_data = 8'hA5; rx_done = 1'b1;
    step(1); rx_done = 1'b0;
    cmp("basic_valid", 32'(m_valid), 1);
    cmp("basic_data", 32'(m_data), 32'h A5);
    m_ready = 1'b1; step(1); m_ready = 1'b0;
    cmp("basic_popped", 32'(m_valid), 0);

    // SYNC restart on a low tick, divisor 2.
    cfg_en = 1'b0; step(3);
    cfg_div = 16'd2; cfg_en = 1'b1;
    step(9);  i_rxd = 1'b0;
    step(2);  i_rxd = 1'b1;
    step(29); cmp("restart_c40", 32'(o_rx_en), 0);
    step(2);  cmp("restart_c42", 32'(o_rx_en), 0);
    step(1);  cmp("restart_c43", 32'(o_rx_en), 1);

    // Overrun with 5 bytes into 4 entries.
    for (int i = 1; i <= 5; i++) begin
      rx_data = 8'(i); rx_done = 1'b1; step(1);
      rx_done = 1'b0; step(1);
    end
    cmp("ovr_fill", 32'(o_fill), 4);
    cmp("ovr_flag", 32'(o_overrun), 1);
    m_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cmp("ovr_drain_valid", 32'(m_valid), 1);
      cmp("ovr_drain_data", 32'(m_data), 32'(i));
      step(1);
    end
    m_ready = 1'b0;
    cmp("ovr_empty", 32'(m_valid), 0);
    clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
    cmp("ovr_cleared", 32'(o_overrun), 0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(8'h11 + i); rx_done = 1'b1; step(1);
      rx_done = 1'b0; step(1);
    end
    cmp("full_fill", 32'(o_fill), 4);
    m_ready = 1'b1; rx_data = 8'h55; rx_done = 1'b1;
    step(1); rx_done = 1'b0; m_ready = 1'b0;
    cmp("pp_fill", 32'(o_fill), 4);
    cmp("pp_overrun", 32'(o_overrun), 0);
    exp4[0] = 8'h12; exp4[1] = 8'h13; exp4[2] = 8'h14; exp4[3] = 8'h55;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cmp("pp_order", 32'(m_data), 32'(exp4[i]));
      step(1);
    end
    m_ready = 1'b0;

    // Held strobe pushes once; disable drains then turns off.
    rx_data = 8'h66; rx_done = 1'b1; step(3); rx_done = 1'b0; step(1);
    cmp("held_once", 32'(o_fill), 1);
    rx_data = 8'h77; rx_done = 1'b1; step(1); rx_done = 1'b0;
    cmp("two_queued", 32'(o_fill), 2);
    cfg_en = 1'b0; step(1);
    cmp("drain_rx_en", 32'(o_rx_en), 0);
    step(4);
    cmp("drain_kept", 32'(o_fill), 2);
    cmp("drain_head", 32'(m_data), 32'h66);
    m_ready = 1'b1; step(2); m_ready = 1'b0;
    cmp("drain_empty", 32'(o_fill), 0);
    step(1);
    for (int i = 0; i < 4; i++) begin
      cmp("off_no_tick", 32'(o_clk_rx), 0);
      step(1);
    end

    // Idle gap with divisor 1.
    cfg_div = 16'd1; cfg_en = 1'b1; i_rxd = 1'b1;
    n = 0;
    while (!o_rx_en && n < 100) begin step(1); n++; end
    cmp("idle_run_reached", 32'(o_rx_en), 1);
    rx_data = 8'h3C; rx_done = 1'b1; step(1); rx_done = 1'b0; m_ready = 1'b1;
    pulses = 0; first = -1;
    for (int k = 1; k <= 900; k++) begin
      if (o_idle) begin
        pulses++;
        if (first < 0) first = k;
      end
      step(1);
    end
    m_ready = 1'b0;
    cmp("idle_pulses", 32'(pulses), 32'(EXP_PULSES));
    cmp("idle_first", 32'(first), 32'(EXP_FIRST));

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      reset   = ($urandom_range(0, 399) == 0);
      if (cfg_en) cfg_en = ($urandom_range(0, 299) != 0);
      else        cfg_en = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) cfg_div = 16'($urandom_range(0, 5));
      i_rxd   = ($urandom_range(0, 29) != 0);
      rx_done = ($urandom_range(0, 5) == 0);
      rx_data = 8'($urandom);
      m_ready = ($urandom_range(0, 2) == 0);
      clr_ovr = ($urandom_range(0, 39) == 0);
      step(1);
    end
    reset = 1'b0; rx_done = 1'b0; clr_ovr = 1'b0;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
